// File: rtl/button_pkg.sv
// button_pkg: per-channel debounce state encoding and default timing (10 MHz board clock)
package button_pkg;

    typedef enum logic [1:0] {UP, WAIT_DOWN, DOWN, WAIT_UP} btn_state_e;

    localparam int DEB_CYCLES_DEF = 200000;
    localparam int REP_DELAY_DEF  = 5000000;
    localparam int REP_RATE_DEF   = 1000000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce: one pushbutton channel; auto-repeat counter only with BUTTON_REPEAT_EN
module button_debounce
    import button_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int REP_DELAY  = REP_DELAY_DEF,
    parameter int REP_RATE   = REP_RATE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    btn_state_e    state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          key_s;

    // synchronized key, still active-low
    assign key_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q    <= 2'b11;
            state_q   <= UP;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_n_i};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            UP:        state_d = key_s ? UP : WAIT_DOWN;
            WAIT_DOWN: begin
                if (key_s) begin
                    state_d = UP;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = DOWN;
                    press_d = 1'b1;
                end else begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                end
            end
            DOWN:      state_d = key_s ? WAIT_UP : DOWN;
            WAIT_UP:   begin
                if (!key_s) begin
                    state_d = DOWN;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = UP;
                    release_d = 1'b1;
                end else begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                end
            end
            default:   state_d = UP;
        endcase
        level_d = (state_d == DOWN) || (state_d == WAIT_UP);
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef BUTTON_REPEAT_EN
    localparam int RMAX = max_int(REP_DELAY, REP_RATE);
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] DELAY_LAST = RW'(REP_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REP_RATE - 1);

    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          rfirst_q, rfirst_d;
    logic          repeat_q, repeat_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rcnt_q   <= '0;
            rfirst_q <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            rcnt_q   <= rcnt_d;
            rfirst_q <= rfirst_d;
            repeat_q <= repeat_d;
        end
    end

    // runs only while the channel stays in DOWN; any exit restarts from the initial delay
    always_comb begin
        rcnt_d   = '0;
        rfirst_d = 1'b0;
        repeat_d = 1'b0;
        if (state_q == DOWN && state_d == DOWN) begin
            rfirst_d = rfirst_q;
            if (rcnt_q == (rfirst_q ? RATE_LAST : DELAY_LAST)) begin
                repeat_d = 1'b1;
                rfirst_d = 1'b1;
            end else begin
                rcnt_d = (rcnt_q == '1) ? rcnt_q : rcnt_q + 1'b1;
            end
        end
    end

    assign repeat_o = repeat_q;
`else
    logic unused_rep;
    assign unused_rep = ^{REP_DELAY, REP_RATE};
    assign repeat_o   = 1'b0;
`endif

endmodule

// File: rtl/button_reader.sv
// button_reader: NBTN independent debounced pushbuttons with press/release pulses;
// auto-repeat pulses are built only when BUTTON_REPEAT_EN is defined
module button_reader
    import button_pkg::*;
#(
    parameter int NBTN       = 4,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int REP_DELAY  = REP_DELAY_DEF,
    parameter int REP_RATE   = REP_RATE_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] key_n,
    output logic [NBTN-1:0] btn_level,
    output logic [NBTN-1:0] btn_press,
    output logic [NBTN-1:0] btn_release,
    output logic [NBTN-1:0] btn_repeat
);

    for (genvar c = 0; c < NBTN; c++) begin : g_ch
        button_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .REP_DELAY  (REP_DELAY),
            .REP_RATE   (REP_RATE)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .key_n_i    (key_n[c]),
            .level_o    (btn_level[c]),
            .press_o    (btn_press[c]),
            .release_o  (btn_release[c]),
            .repeat_o   (btn_repeat[c])
        );
    end

endmodule

// File: tb/tb_button_reader.sv
// tb_button_reader: directed stimulus with a cycle-stamped scoreboard of expected pulses
module tb_button_reader;

    localparam int NBTN  = 4;
    localparam int DEB   = 4;
    localparam int RDLY  = 20;
    localparam int RRATE = 8;
    localparam int LAT   = DEB + 3;

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] rep;
        logic [3:0] set;
        logic [3:0] clr;
    } ev_t;

    ev_t sb[$];

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] key_n = 4'h0;
    logic [3:0] btn_level, btn_press, btn_release, btn_repeat;
    logic [3:0] exp_level = 4'h0;
    logic [3:0] exp_press, exp_rel, exp_rep;
    int         cyc = 0;
    int         vecs = 0;
    int         errs = 0;

    always #5 clk = ~clk;

    button_reader #(
        .NBTN       (NBTN),
        .DEB_CYCLES (DEB),
        .REP_DELAY  (RDLY),
        .REP_RATE   (RRATE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_n),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat)
    );

    function automatic ev_t mk(input int c);
        ev_t e;
        e.cyc   = c;
        e.press = '0;
        e.rel   = '0;
        e.rep   = '0;
        e.set   = '0;
        e.clr   = '0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
        end
    endtask

    // advance one clock, retire due scoreboard entries, compare every output
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        exp_press = '0;
        exp_rel   = '0;
        exp_rep   = '0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            ev_t e;
            e = sb[i];
            if (e.cyc == cyc) begin
                exp_press = exp_press | e.press;
                exp_rel   = exp_rel | e.rel;
                exp_rep   = exp_rep | e.rep;
                exp_level = (exp_level | e.set) & ~e.clr;
                sb.delete(i);
`ifdef BUTTON_REPEAT_EN
                if ((e.press | e.rep) != 4'h0) begin
                    ev_t r;
                    r = mk(cyc + ((e.press != 4'h0) ? RDLY : RRATE));
                    r.rep = e.press | e.rep;
                    sb.push_back(r);
                end
`endif
            end
        end
        check("level", btn_level, exp_level);
        check("press", btn_press, exp_press);
        check("release", btn_release, exp_rel);
        check("repeat", btn_repeat, exp_rep);
    endtask

    task automatic press_keys(input logic [3:0] m);
        ev_t e;
        e = mk(cyc + LAT);
        e.press = m;
        e.set = m;
        key_n = key_n & ~m;
        sb.push_back(e);
    endtask

    // a repeat can still fire up to two edges after release is driven (synchronizer delay)
    task automatic release_keys(input logic [3:0] m);
        ev_t e;
        e = mk(cyc + LAT);
        e.rel = m;
        e.clr = m;
        key_n = key_n | m;
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].cyc > cyc + 2) sb[i].rep = sb[i].rep & ~m;
        sb.push_back(e);
    endtask

    task automatic reset_assert();
        ev_t e;
        e = mk(cyc + 1);
        e.clr = 4'hF;
        rst = 1'b0;
        sb.delete();
        sb.push_back(e);
    endtask

    task automatic reset_release();
        ev_t e;
        e = mk(cyc + LAT);
        e.press = ~key_n;
        e.set = ~key_n;
        rst = 1'b1;
        sb.push_back(e);
    endtask

    initial begin
        // reset with every key held, then all reported as fresh presses
        rst = 1'b0;
        key_n = 4'h0;
        repeat (3) tick();
        reset_release();
        repeat (10) tick();
        release_keys(4'hF);
        repeat (10) tick();
        // clean press/release on channel 0
        press_keys(4'b0001);
        repeat (10) tick();
        release_keys(4'b0001);
        repeat (10) tick();
        // bounce on channel 1: low 3, high 1, then held low
        key_n[1] = 1'b0;
        repeat (3) tick();
        key_n[1] = 1'b1;
        tick();
        press_keys(4'b0010);
        repeat (10) tick();
        release_keys(4'b0010);
        repeat (10) tick();
        // simultaneous press on channels 2 and 3
        press_keys(4'b1100);
        repeat (10) tick();
        release_keys(4'b1100);
        repeat (10) tick();
        // long hold on channel 0 for auto-repeat
        press_keys(4'b0001);
        repeat (60) tick();
        release_keys(4'b0001);
        repeat (10) tick();
        // reset while channel 0 is mid-debounce (count 2)
        key_n[0] = 1'b0;
        repeat (5) tick();
        reset_assert();
        repeat (2) tick();
        reset_release();
        repeat (12) tick();
        release_keys(4'b0001);
        repeat (10) tick();
        // reset while channel 0 is held down
        press_keys(4'b0001);
        repeat (10) tick();
        reset_assert();
        repeat (2) tick();
        reset_release();
        repeat (12) tick();
        release_keys(4'b0001);
        repeat (10) tick();
        // short release glitch on held channel 3
        press_keys(4'b1000);
        repeat (10) tick();
        key_n[3] = 1'b1;
        repeat (2) tick();
        key_n[3] = 1'b0;
        repeat (10) tick();
        release_keys(4'b1000);
        repeat (10) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/button_reader.md
BUTTON_READER -- requirements
Module: button_reader

Interface
REQ-001 Parameter NBTN, default 4: number of pushbutton channels, 1..16.
REQ-002 Parameter DEB_CYCLES, default 200000: stable clocks required to accept a level change (20 ms at 10 MHz), >= 2.
REQ-003 Parameter REP_DELAY, default 5000000: clocks from accepted press to first repeat pulse (500 ms).
REQ-004 Parameter REP_RATE, default 1000000: clocks between subsequent repeat pulses (100 ms).
REQ-005 Port clk, input, 1: single system clock (10 MHz on board); all logic on its rising edge.
REQ-006 Port rst, input, 1: reset, synchronous, active-low.
REQ-007 Port key_n, input, NBTN: raw asynchronous pushbuttons, active-low (0 = pressed).
REQ-008 Port btn_level, output, NBTN: debounced state, 1 = pressed.
REQ-009 Port btn_press, output, NBTN: one-cycle pulse on accepted press.
REQ-010 Port btn_release, output, NBTN: one-cycle pulse on accepted release.
REQ-011 Port btn_repeat, output, NBTN: one-cycle auto-repeat pulse while held.

Function
REQ-012 Each key_n bit passes through a 2-flop synchronizer before any other use.
REQ-013 Each channel has an independent FSM with states UP, WAIT_DOWN, DOWN, WAIT_UP.
REQ-014 UP -> WAIT_DOWN when the synchronized input is 0; the debounce counter clears.
REQ-015 In WAIT_DOWN:
- Counter increments each cycle the input stays 0.
- Input returns to 1 before the counter reaches DEB_CYCLES-1: back to UP, counter cleared, no pulse.
- Counter == DEB_CYCLES-1 with input still 0: DOWN on the next edge, btn_level=1, btn_press high for exactly that one cycle.
REQ-016 DOWN -> WAIT_UP and WAIT_UP -> UP follow the same rules mirrored. On UP entry: btn_level=0, btn_release one-cycle pulse.
REQ-017 Latency from the first clock edge that samples key_n low to btn_press high is exactly DEB_CYCLES+2 cycles; release latency is identical.
REQ-018 A glitch shorter than DEB_CYCLES cycles produces no pulse and leaves btn_level unchanged.
REQ-019 btn_press, btn_release and btn_repeat are never high in the same cycle on one channel.
REQ-020 Channels are fully independent; simultaneous events on several channels each pulse in their own bit, in the same cycle.
REQ-021 Counters saturate and never wrap. Each counter is $clog2 of the largest parameter it compares against.

Reset
REQ-022 While rst=0 at a clock edge:
- Synchronizer flops load 1.
- FSMs load UP; all counters load 0.
- All outputs are 0.
REQ-023 Reset asserted mid-debounce or mid-hold aborts without emitting any pulse.
REQ-024 After rst rises, a key already held low is reported as a fresh press after DEB_CYCLES+2 cycles.

Configuration
REQ-025 Macro BUTTON_REPEAT_EN defined: in DOWN, a per-channel repeat counter runs.
- First btn_repeat pulse comes REP_DELAY cycles after the btn_press cycle; further pulses every REP_RATE cycles.
- Leaving DOWN clears the repeat counter.
REQ-026 Macro BUTTON_REPEAT_EN undefined: no repeat counters are synthesized and btn_repeat is constant 0.

Structure
REQ-027 Package button_pkg holds the FSM state enum typedef (UP, WAIT_DOWN, DOWN, WAIT_UP) and the default timing constants.
REQ-028 Sub-module button_debounce implements one channel (synchronizer, FSM, counters, optional repeat). button_reader instantiates it NBTN times via generate.

Verification
All scenarios use NBTN=4, DEB_CYCLES=4, REP_DELAY=20, REP_RATE=8.
REQ-029 Reset: rst=0 for 3 cycles with key_n=4'b0000 -> all outputs 0. After rst=1, btn_press=4'b1111 for one cycle 6 cycles later.
REQ-030 Clean press: key_n[0] falls and is held -> btn_press[0] one cycle at +6 and btn_level[0]=1 from then. Release -> btn_release[0] at +6.
REQ-031 Bounce: key_n[1] low 3 cycles, high 1 cycle, low held -> no pulse during the bounce; btn_press[1] 6 cycles after the final fall.
REQ-032 Simultaneous: key_n[2] and key_n[3] fall on the same edge -> btn_press=4'b1100 in one cycle.
REQ-033 Repeat with BUTTON_REPEAT_EN: hold key_n[0] for 60 cycles -> btn_repeat[0] at press+20, +28, +36, +44, +52. Same run without the macro -> btn_repeat stays 0.
REQ-034 Reset mid-operation: rst=0 while channel 0 is in WAIT_DOWN with count 2 -> no btn_press; after rst=1 the count restarts from 0.
